// File: rtl/neighbor_builder.sv
// neighbor_builder: fills RAM_NBR with per-vertex neighbor lists taken from the faces in RAM_OBJ.
// Ports: clk/rst/start, vertex_count/face_count, RAM_OBJ_* and RAM_NBR_* ports, busy/done/overflow/bad_index.
module neighbor_builder #(
    parameter int ADDR_WIDTH         = 9,
    parameter int MAX_NEIGHBOR_COUNT = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           vertex_count,
    input  logic [31:0]           face_count,
    input  logic [31:0]           RAM_OBJ_Do,
    output logic                  RAM_OBJ_EN,
    output logic [3:0]            RAM_OBJ_WE,
    output logic [ADDR_WIDTH-1:0] RAM_OBJ_A,
    output logic [31:0]           RAM_OBJ_Di,
    input  logic [31:0]           RAM_NBR_Do,
    output logic                  RAM_NBR_EN,
    output logic [3:0]            RAM_NBR_WE,
    output logic [ADDR_WIDTH-1:0] RAM_NBR_A,
    output logic [31:0]           RAM_NBR_Di,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  bad_index
);

    typedef enum logic [2:0] {
        IDLE, CLEAR, FACE_RD, EDGE_CNT,
        EDGE_SCAN, EDGE_WR_NBR, EDGE_WR_CNT, DONE
    } state_t;

    localparam logic [31:0] MAXW = 32'(MAX_NEIGHBOR_COUNT);
    localparam logic [31:0] FULL = MAXW - 32'd1;
    localparam logic [ADDR_WIDTH-1:0] A1 = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A2 = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A3 = ADDR_WIDTH'(3);

    state_t                  state;
    logic [31:0]             vc, fc, clr_v, face_idx;
    logic [31:0]             a, b, c, u, w, cnt, scan_i;
    logic [1:0]              ph;
    logic [2:0]              pair;
    logic [ADDR_WIDTH-1:0]   face_addr, base;

    function automatic logic [ADDR_WIDTH-1:0] base_of(input logic [31:0] v);
        return ADDR_WIDTH'((v - 32'd1) * MAXW);
    endfunction

    // Ordered pair p of the face: a>b, a>c, b>a, b>c, c>a, c>b
    function automatic logic [63:0] pick(input logic [2:0] p,
                                         input logic [31:0] x,
                                         input logic [31:0] y,
                                         input logic [31:0] z);
        case (p)
            3'd0:    return {x, y};
            3'd1:    return {x, z};
            3'd2:    return {y, x};
            3'd3:    return {y, z};
            3'd4:    return {z, x};
            default: return {z, y};
        endcase
    endfunction

    function automatic logic bad_idx(input logic [31:0] i, input logic [31:0] n);
        return (i == 32'd0) || (i > n);
    endfunction

    assign RAM_OBJ_WE = 4'd0;
    assign RAM_OBJ_Di = 32'd0;

    logic [31:0] np_u, np_w;
    logic        adv_pair, bad_face, adv_face, face_last, adv_done;

    assign {np_u, np_w} = pick(pair + 3'd1, a, b, c);

    // adv_pair: the current ordered pair is finished (inserted, duplicate, self or full)
    always_comb begin
        adv_pair = 1'b0;
        bad_face = 1'b0;
        case (state)
            FACE_RD:
                bad_face = (ph == 2'd3) &&
                           (bad_idx(a, vc) || bad_idx(b, vc) || bad_idx(c, vc));
            EDGE_CNT:
                adv_pair = (u == w);
            EDGE_SCAN:
                adv_pair = (RAM_NBR_Do == w) || ((scan_i == cnt) && (cnt == FULL));
            EDGE_WR_CNT:
                adv_pair = 1'b1;
            default: ;
        endcase
    end

    assign face_last = (face_idx == fc - 32'd1);
    assign adv_face  = (adv_pair && pair == 3'd5) || bad_face;
    assign adv_done  = (adv_face && face_last) ||
                       (state == CLEAR && clr_v == vc && fc == 32'd0) ||
                       (state == IDLE && start && vertex_count == 32'd0);

    // Registers move on the falling edge so addresses are stable at the RAM's rising edge
    always_ff @(negedge clk) begin
        if (rst) begin
            state      <= IDLE;
            vc         <= '0;
            fc         <= '0;
            clr_v      <= '0;
            face_idx   <= '0;
            a          <= '0;
            b          <= '0;
            c          <= '0;
            u          <= '0;
            w          <= '0;
            cnt        <= '0;
            scan_i     <= '0;
            ph         <= '0;
            pair       <= '0;
            face_addr  <= '0;
            base       <= '0;
            RAM_OBJ_EN <= 1'b0;
            RAM_OBJ_A  <= '0;
            RAM_NBR_EN <= 1'b0;
            RAM_NBR_WE <= 4'd0;
            RAM_NBR_A  <= '0;
            RAM_NBR_Di <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            bad_index  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy       <= 1'b1;
                        overflow   <= 1'b0;
                        bad_index  <= 1'b0;
                        RAM_OBJ_EN <= 1'b1;
                        RAM_NBR_EN <= 1'b1;
                        vc         <= vertex_count;
                        fc         <= face_count;
                        clr_v      <= 32'd1;
                        RAM_NBR_A  <= '0;
                        RAM_NBR_WE <= 4'hF;
                        RAM_NBR_Di <= '0;
                        state      <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (clr_v == vc) begin
                        RAM_NBR_WE <= 4'd0;
                        face_idx   <= '0;
                        face_addr  <= ADDR_WIDTH'(vc * 32'd3 + 32'd1);
                        RAM_OBJ_A  <= ADDR_WIDTH'(vc * 32'd3 + 32'd1);
                        ph         <= '0;
                        state      <= FACE_RD;
                    end else begin
                        clr_v     <= clr_v + 32'd1;
                        RAM_NBR_A <= base_of(clr_v + 32'd1);
                    end
                end
                FACE_RD: begin
                    ph <= ph + 2'd1;
                    unique case (ph)
                        2'd0: begin
                            a         <= RAM_OBJ_Do;
                            RAM_OBJ_A <= face_addr + A1;
                        end
                        2'd1: begin
                            b         <= RAM_OBJ_Do;
                            RAM_OBJ_A <= face_addr + A2;
                        end
                        2'd2: c <= RAM_OBJ_Do;
                        2'd3: begin
                            if (bad_face) begin
                                bad_index <= 1'b1;
                            end else begin
                                pair      <= '0;
                                u         <= a;
                                w         <= b;
                                base      <= base_of(a);
                                RAM_NBR_A <= base_of(a);
                                state     <= EDGE_CNT;
                            end
                        end
                    endcase
                end
                EDGE_CNT: begin
                    if (u != w) begin
                        cnt <= RAM_NBR_Do;
                        if (RAM_NBR_Do == 32'd0) begin
                            RAM_NBR_A  <= base + A1;
                            RAM_NBR_Di <= w;
                            RAM_NBR_WE <= 4'hF;
                            state      <= EDGE_WR_NBR;
                        end else begin
                            scan_i    <= 32'd1;
                            RAM_NBR_A <= base + A1;
                            state     <= EDGE_SCAN;
                        end
                    end
                end
                EDGE_SCAN: begin
                    if (RAM_NBR_Do != w) begin
                        if (scan_i == cnt) begin
                            if (cnt == FULL) begin
                                overflow <= 1'b1;
                            end else begin
                                RAM_NBR_A  <= base + ADDR_WIDTH'(cnt + 32'd1);
                                RAM_NBR_Di <= w;
                                RAM_NBR_WE <= 4'hF;
                                state      <= EDGE_WR_NBR;
                            end
                        end else begin
                            scan_i    <= scan_i + 32'd1;
                            RAM_NBR_A <= RAM_NBR_A + A1;
                        end
                    end
                end
                EDGE_WR_NBR: begin
                    RAM_NBR_A  <= base;
                    RAM_NBR_Di <= cnt + 32'd1;
                    state      <= EDGE_WR_CNT;
                end
                EDGE_WR_CNT: begin
                    RAM_NBR_WE <= 4'd0;
                    RAM_NBR_Di <= '0;
                end
                DONE: begin
                    done      <= 1'b0;
                    overflow  <= 1'b0;
                    bad_index <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (adv_pair && pair != 3'd5) begin
                pair       <= pair + 3'd1;
                u          <= np_u;
                w          <= np_w;
                base       <= base_of(np_u);
                RAM_NBR_A  <= base_of(np_u);
                RAM_NBR_WE <= 4'd0;
                state      <= EDGE_CNT;
            end
            if (adv_face && !face_last) begin
                face_idx   <= face_idx + 32'd1;
                face_addr  <= face_addr + A3;
                RAM_OBJ_A  <= face_addr + A3;
                ph         <= '0;
                RAM_NBR_WE <= 4'd0;
                state      <= FACE_RD;
            end
            if (adv_done) begin
                done       <= 1'b1;
                busy       <= 1'b0;
                RAM_OBJ_EN <= 1'b0;
                RAM_OBJ_A  <= '0;
                RAM_NBR_EN <= 1'b0;
                RAM_NBR_WE <= 4'd0;
                RAM_NBR_A  <= '0;
                RAM_NBR_Di <= '0;
                state      <= DONE;
            end
        end
    end

endmodule

// File: tb/tb_neighbor_builder.sv
// tb_neighbor_builder: drives mesh builds into neighbor_builder over behavioural RAMs
// and scores each finished table against a list-based reference model.
module tb_neighbor_builder;

    localparam int AW   = 9;
    localparam int MAXN = 10;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [31:0]   vertex_count, face_count;
    logic [31:0]   obj_do, nbr_do;
    logic          obj_en, nbr_en;
    logic [3:0]    obj_we, nbr_we;
    logic [AW-1:0] obj_a, nbr_a;
    logic [31:0]   obj_di, nbr_di;
    logic          busy, done, overflow, bad_index;

    neighbor_builder #(.ADDR_WIDTH(AW), .MAX_NEIGHBOR_COUNT(MAXN)) dut (
        .clk(clk), .rst(rst), .start(start),
        .vertex_count(vertex_count), .face_count(face_count),
        .RAM_OBJ_Do(obj_do), .RAM_OBJ_EN(obj_en), .RAM_OBJ_WE(obj_we),
        .RAM_OBJ_A(obj_a), .RAM_OBJ_Di(obj_di),
        .RAM_NBR_Do(nbr_do), .RAM_NBR_EN(nbr_en), .RAM_NBR_WE(nbr_we),
        .RAM_NBR_A(nbr_a), .RAM_NBR_Di(nbr_di),
        .busy(busy), .done(done), .overflow(overflow), .bad_index(bad_index)
    );

    always #5 clk = ~clk;

    logic [31:0] obj_mem [0:511];
    logic [31:0] nbr_mem [0:511];
    bit          obj_wr_seen = 1'b0;

    always @(posedge clk) begin
        if (obj_en) obj_do <= obj_mem[obj_a];
        if (obj_we != 4'd0 || obj_di != 32'd0) obj_wr_seen <= 1'b1;
        if (nbr_en) begin
            if (nbr_we == 4'hF) nbr_mem[nbr_a] <= nbr_di;
            nbr_do <= nbr_mem[nbr_a];
        end
    end

    int checks = 0;
    int failures = 0;
    int done_seen = 0;

    int fa [0:63];
    int fb [0:63];
    int fcc [0:63];
    int exp_cnt [0:63];
    int exp_nb [0:63][0:15];

    typedef struct {
        int vc;
        bit ovf;
        bit bad;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    // Reference: every valid face offers its six ordered pairs;
    // a vertex list keeps first-seen order, no self/dup, at most MAXN-1 entries.
    task automatic model(input int vc, input int nf, output bit ovf, output bit bad);
        int t[3];
        ovf = 1'b0;
        bad = 1'b0;
        for (int v = 0; v < 64; v++) exp_cnt[v] = 0;
        for (int f = 0; f < nf; f++) begin
            t[0] = fa[f];
            t[1] = fb[f];
            t[2] = fcc[f];
            if (t[0] < 1 || t[0] > vc || t[1] < 1 || t[1] > vc ||
                t[2] < 1 || t[2] > vc) begin
                bad = 1'b1;
                continue;
            end
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    int uu, ww;
                    bit found;
                    if (i == j) continue;
                    uu = t[i];
                    ww = t[j];
                    if (uu == ww) continue;
                    found = 1'b0;
                    for (int k = 0; k < exp_cnt[uu]; k++)
                        if (exp_nb[uu][k] == ww) found = 1'b1;
                    if (found) continue;
                    if (exp_cnt[uu] == MAXN - 1) begin
                        ovf = 1'b1;
                        continue;
                    end
                    exp_nb[uu][exp_cnt[uu]] = ww;
                    exp_cnt[uu]++;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done got=1 want=0");
            end else begin
                e = sb.pop_front();
                chk("overflow", overflow, e.ovf);
                chk("bad_index", bad_index, e.bad);
                chk("busy_at_done", busy, 0);
                chk("nbr_en_at_done", nbr_en, 0);
                chk("obj_write", obj_wr_seen, 0);
                for (int v = 1; v <= e.vc; v++) begin
                    int bs;
                    bs = (v - 1) * MAXN;
                    chk($sformatf("cnt_v%0d", v), nbr_mem[bs], exp_cnt[v]);
                    for (int k = 0; k < exp_cnt[v]; k++)
                        chk($sformatf("nbr_v%0d_%0d", v, k + 1),
                            nbr_mem[bs + 1 + k], exp_nb[v][k]);
                end
            end
            done_seen++;
        end
    end

    task automatic prep(input int vc, input int nf);
        for (int i = 0; i < 512; i++) begin
            obj_mem[i] = $urandom;
            nbr_mem[i] <= $urandom;
        end
        for (int f = 0; f < nf; f++) begin
            obj_mem[3 * vc + 1 + 3 * f] = fa[f];
            obj_mem[3 * vc + 2 + 3 * f] = fb[f];
            obj_mem[3 * vc + 3 + 3 * f] = fcc[f];
        end
        @(posedge clk);
        vertex_count = vc;
        face_count = nf;
    endtask

    task automatic run(input int vc, input int nf, input bit extra);
        bit ovf, bad;
        int target;
        prep(vc, nf);
        model(vc, nf, ovf, bad);
        sb.push_back('{vc, ovf, bad});
        target = done_seen + 1;
        start = 1'b1;
        @(posedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(posedge clk);
            if (done_seen >= target) break;
            start = extra && cyc < 60 && (cyc % 9) == 4;
        end
        start = 1'b0;
        chk("done_reached", done_seen >= target, 1);
        if (done_seen < target) sb.delete();
        repeat (2) @(posedge clk);
    endtask

    task automatic set_face(input int f, input int x, input int y, input int z);
        fa[f] = x;
        fb[f] = y;
        fcc[f] = z;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        vertex_count = 0;
        face_count = 0;
        repeat (3) @(posedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_bad_index", bad_index, 0);
        chk("rst_obj_en", obj_en, 0);
        chk("rst_obj_a", obj_a, 0);
        chk("rst_nbr_en", nbr_en, 0);
        chk("rst_nbr_we", nbr_we, 0);
        chk("rst_nbr_a", nbr_a, 0);
        chk("rst_nbr_di", nbr_di, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        set_face(0, 1, 2, 3);
        run(3, 1, 1'b0);
        chk("t2_w0", nbr_mem[0], 2);
        chk("t2_w1", nbr_mem[1], 2);
        chk("t2_w2", nbr_mem[2], 3);
        chk("t2_w10", nbr_mem[10], 2);
        chk("t2_w11", nbr_mem[11], 1);
        chk("t2_w12", nbr_mem[12], 3);
        chk("t2_w20", nbr_mem[20], 2);
        chk("t2_w21", nbr_mem[21], 1);
        chk("t2_w22", nbr_mem[22], 2);
        chk("idle_flags", {overflow, bad_index, busy}, 0);

        set_face(0, 1, 2, 3);
        set_face(1, 1, 3, 4);
        run(4, 2, 1'b0);

        for (int k = 2; k <= 11; k++) set_face(k - 2, 1, k, k + 1);
        run(12, 10, 1'b0);

        set_face(0, 1, 1, 2);
        set_face(1, 0, 2, 3);
        run(3, 2, 1'b0);

        run(3, 0, 1'b0);
        run(0, 0, 1'b0);

        set_face(0, 1, 2, 3);
        prep(3, 1);
        start = 1'b1;
        @(posedge clk);
        start = 1'b0;
        repeat (12) @(posedge clk);
        rst = 1'b1;
        @(posedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_nbr_en", nbr_en, 0);
        chk("abort_nbr_we", nbr_we, 0);
        chk("abort_obj_en", obj_en, 0);
        repeat (20) @(posedge clk);
        run(3, 1, 1'b1);

        for (int r = 0; r < 20; r++) begin
            int vc, nf;
            vc = $urandom_range(2, 12);
            nf = $urandom_range(1, 10);
            for (int f = 0; f < nf; f++) begin
                int t[3];
                for (int i = 0; i < 3; i++) begin
                    int sel;
                    sel = $urandom_range(0, 15);
                    if (sel == 0) t[i] = 0;
                    else if (sel == 1) t[i] = vc + 1;
                    else t[i] = $urandom_range(1, vc);
                end
                set_face(f, t[0], t[1], t[2]);
            end
            run(vc, nf, r[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
